// File: rtl/int_seq.sv
// int_seq: interrupt entry/exit sequencer sitting between int_ctrl and the
// LS1u core.
//
// An interrupt request is accepted only when global enable (GIE) is set.
// The sequencer waits for an instruction boundary, captures the return PC,
// the winning code and the vector, stalls the core for FLUSH_CYC cycles and
// then issues a one-cycle redirect to the vector. Further requests are
// ignored until the core executes RETI. The sequencer then redirects back to
// the saved EPC, which the ISR may have rewritten.
//
// Parameters:
//   FLUSH_CYC  stall cycles between capture and vector jump (1..15)
//   CNT_W      width of the saturating entry and spurious counters
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   INT_REQ, IVEC_ADDR_i,
//   INT_CODE_i                request, vector and code from int_ctrl
//   BOUNDARY_i, PC_i, RETI_i  core retire strobe, next PC, RETI pulse
//   STALL_o, JMP_o,
//   JMP_ADDR_o, INT_ACT_o     core stall, redirect strobe/target, ISR active
//   WB_*                      8-bit zero-wait Wishbone register file
//
// Register map (byte wide):
//   0 CTRL {GIE, 0000, state}   1..3 EPC bytes   4 CODE
//   5 ENTRY_CNT (write clears)  6 SPUR_CNT (write clears)   7 reads 0
module int_seq #(
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT_REQ,
  input  logic [23:0] IVEC_ADDR_i,
  input  logic [2:0]  INT_CODE_i,
  input  logic        BOUNDARY_i,
  input  logic [23:0] PC_i,
  input  logic        RETI_i,
  output logic        STALL_o,
  output logic        JMP_o,
  output logic [23:0] JMP_ADDR_o,
  output logic        INT_ACT_o,
  input  logic [2:0]  WB_ADRi,
  input  logic [7:0]  WB_DATi,
  output logic [7:0]  WB_DATo,
  input  logic        WB_WEi,
  input  logic        WB_CYCi,
  input  logic        WB_STBi,
  output logic        WB_ACKo
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    FLUSH = 3'd2,
    JUMP  = 3'd3,
    ISR   = 3'd4,
    RET   = 3'd5
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             gie_q, gie_d;
  logic [23:0]      epc_q, epc_d;
  logic [2:0]       code_q, code_d;
  logic [23:0]      vec_q, vec_d;
  logic [3:0]       flush_cnt_q, flush_cnt_d;
  logic [23:0]      jmp_addr_q, jmp_addr_d;
  logic [CNT_W-1:0] entry_cnt_q, entry_cnt_d;
  logic [CNT_W-1:0] spur_cnt_q, spur_cnt_d;

  logic       wb_wr;
  logic       capture;
  logic       entry_inc;
  logic       spur_inc;
  logic [7:0] entry_rd;
  logic [7:0] spur_rd;

  assign wb_wr   = WB_CYCi & WB_STBi & WB_WEi;
  assign WB_ACKo = 1'b1;

  // Outputs decode straight from the state register, so an asynchronous
  // reset drops STALL_o and JMP_o at once.
  assign STALL_o    = (state_q == FLUSH) || (state_q == JUMP);
  assign JMP_o      = (state_q == JUMP) || (state_q == RET);
  assign INT_ACT_o  = (state_q == ISR);
  assign JMP_ADDR_o = jmp_addr_q;

  // The redirect target is loaded on the edge that enters JUMP or RET and
  // then held. Loading EPC on the RETI edge makes RET use the pre-write EPC
  // when an ISR write to EPC lands in that same cycle.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    jmp_addr_d  = jmp_addr_q;
    capture     = 1'b0;
    entry_inc   = 1'b0;
    spur_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (INT_REQ && gie_q) state_d = ARM;
      end
      ARM: begin
        // A request that vanishes counts as spurious, even when a boundary
        // arrives in the same cycle.
        if (!INT_REQ) begin
          state_d  = IDLE;
          spur_inc = 1'b1;
        end else if (!gie_q) begin
          state_d = IDLE;
        end else if (BOUNDARY_i) begin
          capture     = 1'b1;
          flush_cnt_d = FLUSH_LOAD;
          state_d     = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 4'd0) begin
          state_d    = JUMP;
          jmp_addr_d = vec_q;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      JUMP: begin
        entry_inc = 1'b1;
        state_d   = ISR;
      end
      ISR: begin
        if (RETI_i) begin
          state_d    = RET;
          jmp_addr_d = epc_q;
        end
      end
      RET: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register file updates. Capture at the boundary overrides a concurrent
  // bus write to EPC; a clear write overrides a concurrent counter increment.
  always_comb begin
    gie_d       = gie_q;
    epc_d       = epc_q;
    code_d      = code_q;
    vec_d       = vec_q;
    entry_cnt_d = entry_cnt_q;
    spur_cnt_d  = spur_cnt_q;

    if (wb_wr) begin
      case (WB_ADRi)
        3'd0:    gie_d         = WB_DATi[7];
        3'd1:    epc_d[7:0]    = WB_DATi;
        3'd2:    epc_d[15:8]   = WB_DATi;
        3'd3:    epc_d[23:16]  = WB_DATi;
        default: begin
        end
      endcase
    end

    if (capture) begin
      epc_d  = PC_i;
      code_d = INT_CODE_i;
      vec_d  = IVEC_ADDR_i;
    end

    if (wb_wr && (WB_ADRi == 3'd5)) begin
      entry_cnt_d = '0;
    end else if (entry_inc && (entry_cnt_q != {CNT_W{1'b1}})) begin
      entry_cnt_d = entry_cnt_q + CNT_ONE;
    end

    if (wb_wr && (WB_ADRi == 3'd6)) begin
      spur_cnt_d = '0;
    end else if (spur_inc && (spur_cnt_q != {CNT_W{1'b1}})) begin
      spur_cnt_d = spur_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gie_q       <= 1'b0;
      epc_q       <= '0;
      code_q      <= '0;
      vec_q       <= '0;
      flush_cnt_q <= '0;
      jmp_addr_q  <= '0;
      entry_cnt_q <= '0;
      spur_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      gie_q       <= gie_d;
      epc_q       <= epc_d;
      code_q      <= code_d;
      vec_q       <= vec_d;
      flush_cnt_q <= flush_cnt_d;
      jmp_addr_q  <= jmp_addr_d;
      entry_cnt_q <= entry_cnt_d;
      spur_cnt_q  <= spur_cnt_d;
    end
  end

  // Counters are presented on the 8-bit bus zero-extended or truncated.
  generate
    if (CNT_W >= 8) begin : g_cnt_wide
      assign entry_rd = entry_cnt_q[7:0];
      assign spur_rd  = spur_cnt_q[7:0];
    end else begin : g_cnt_narrow
      assign entry_rd = {{(8-CNT_W){1'b0}}, entry_cnt_q};
      assign spur_rd  = {{(8-CNT_W){1'b0}}, spur_cnt_q};
    end
  endgenerate

  always_comb begin
    WB_DATo = 8'h00;
    case (WB_ADRi)
      3'd0: WB_DATo = {gie_q, 4'b0000, state_q};
      3'd1: WB_DATo = epc_q[7:0];
      3'd2: WB_DATo = epc_q[15:8];
      3'd3: WB_DATo = epc_q[23:16];
      3'd4: WB_DATo = {5'b00000, code_q};
      3'd5: WB_DATo = entry_rd;
      3'd6: WB_DATo = spur_rd;
      3'd7: WB_DATo = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_int_seq.sv
`timescale 1ns/100ps
// Directed testbench for int_seq: entry/exit sequencing, spurious requests,
// EPC rewrite by the ISR, asynchronous reset mid-sequence and counter
// saturation. Inputs change 1 ns after the rising edge, and outputs are
// sampled at that point as well.
module tb_int_seq;

   localparam int FLUSH_CYC = 2;
   localparam int CNT_W     = 8;

   logic        clk;
   logic        rst;
   logic        INT_REQ;
   logic [23:0] IVEC_ADDR_i;
   logic [2:0]  INT_CODE_i;
   logic        BOUNDARY_i;
   logic [23:0] PC_i;
   logic        RETI_i;
   logic        STALL_o;
   logic        JMP_o;
   logic [23:0] JMP_ADDR_o;
   logic        INT_ACT_o;
   logic [2:0]  WB_ADRi;
   logic [7:0]  WB_DATi;
   logic [7:0]  WB_DATo;
   logic        WB_WEi;
   logic        WB_CYCi;
   logic        WB_STBi;
   logic        WB_ACKo;

   int testCount = 0;
   int failCount = 0;

   int_seq #(.FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .INT_REQ(INT_REQ), .IVEC_ADDR_i(IVEC_ADDR_i), .INT_CODE_i(INT_CODE_i),
      .BOUNDARY_i(BOUNDARY_i), .PC_i(PC_i), .RETI_i(RETI_i),
      .STALL_o(STALL_o), .JMP_o(JMP_o), .JMP_ADDR_o(JMP_ADDR_o),
      .INT_ACT_o(INT_ACT_o),
      .WB_ADRi(WB_ADRi), .WB_DATi(WB_DATi), .WB_DATo(WB_DATo),
      .WB_WEi(WB_WEi), .WB_CYCi(WB_CYCi), .WB_STBi(WB_STBi),
      .WB_ACKo(WB_ACKo)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compares one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advances one clock and settles just past the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives the core-side inputs for the next edge.
   task automatic applyStimulus(input logic req, input logic bnd,
                                input logic [23:0] pc, input logic reti);
      INT_REQ    = req;
      BOUNDARY_i = bnd;
      PC_i       = pc;
      RETI_i     = reti;
   endtask

   // A single-cycle bus write; the register updates on the edge inside.
   task automatic wbWrite(input logic [2:0] adr, input logic [7:0] dat);
      WB_ADRi = adr;
      WB_DATi = dat;
      WB_CYCi = 1'b1;
      WB_STBi = 1'b1;
      WB_WEi  = 1'b1;
      tick();
      WB_CYCi = 1'b0;
      WB_STBi = 1'b0;
      WB_WEi  = 1'b0;
   endtask

   // Combinational read, checked against the expected register value.
   task automatic checkReg(input string tag, input logic [2:0] adr,
                           input logic [7:0] expected);
      WB_ADRi = adr;
      WB_WEi  = 1'b0;
      #0.2;
      checkOutput(tag, {24'h0, WB_DATo}, {24'h0, expected});
   endtask

   // From IDLE with GIE set: request, boundary at pc, flush, vector jump.
   // Returns with the sequencer in ISR.
   task automatic enterIsr(input logic [23:0] pc, input logic [23:0] vec,
                           input logic [2:0] code, input logic clrAtJump);
      IVEC_ADDR_i = vec;
      INT_CODE_i  = code;
      applyStimulus(1'b1, 1'b0, pc, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, pc, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, pc, 1'b0);
      repeat (FLUSH_CYC) tick();
      checkOutput("entry_jmp", JMP_o, 1'b1);
      checkOutput("entry_addr", JMP_ADDR_o, vec);
      if (clrAtJump) wbWrite(3'd5, 8'h00);
      else tick();
      checkOutput("entry_act", INT_ACT_o, 1'b1);
   endtask

   // RETI from ISR, expecting a return jump to epc, then one IDLE cycle.
   task automatic exitIsr(input logic [23:0] epc);
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
      tick();
      checkOutput("exit_jmp", JMP_o, 1'b1);
      checkOutput("exit_addr", JMP_ADDR_o, epc);
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
      tick();
      checkOutput("exit_idle", JMP_o, 1'b0);
   endtask

   // Main directed sequence.
   initial begin
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
      IVEC_ADDR_i = 24'h0;
      INT_CODE_i  = 3'd0;
      WB_ADRi = 3'd0;
      WB_DATi = 8'h00;
      WB_WEi  = 1'b0;
      WB_CYCi = 1'b0;
      WB_STBi = 1'b0;

      // Reset state.
      #12;
      checkOutput("rst_stall", STALL_o, 1'b0);
      checkOutput("rst_jmp", JMP_o, 1'b0);
      checkOutput("rst_act", INT_ACT_o, 1'b0);
      checkOutput("rst_jaddr", JMP_ADDR_o, 24'h0);
      checkOutput("rst_ack", WB_ACKo, 1'b1);
      rst = 1'b1;
      tick();
      checkReg("rst_ctrl", 3'd0, 8'h00);
      checkReg("rst_entry", 3'd5, 8'h00);
      checkReg("rst_spur", 3'd6, 8'h00);
      checkReg("rst_epc0", 3'd1, 8'h00);

      wbWrite(3'd0, 8'h80);
      checkReg("gie_set", 3'd0, 8'h80);

      // First entry: code 5, vector 0x001020, boundary at 0x000400.
      IVEC_ADDR_i = 24'h001020;
      INT_CODE_i  = 3'd5;
      applyStimulus(1'b1, 1'b0, 24'h000300, 1'b0);
      tick();
      checkReg("arm_ctrl", 3'd0, 8'h81);
      checkOutput("arm_stall", STALL_o, 1'b0);
      applyStimulus(1'b1, 1'b1, 24'h000400, 1'b0);
      tick();
      checkOutput("flush1_stall", STALL_o, 1'b1);
      checkOutput("flush1_jmp", JMP_o, 1'b0);
      // Vector and code must stay frozen after capture.
      applyStimulus(1'b1, 1'b0, 24'h000404, 1'b0);
      IVEC_ADDR_i = 24'h00ABCD;
      INT_CODE_i  = 3'd2;
      tick();
      checkOutput("flush2_stall", STALL_o, 1'b1);
      checkOutput("flush2_jmp", JMP_o, 1'b0);
      checkReg("flush_ctrl", 3'd0, 8'h82);
      tick();
      checkOutput("jump_jmp", JMP_o, 1'b1);
      checkOutput("jump_addr", JMP_ADDR_o, 24'h001020);
      checkOutput("jump_stall", STALL_o, 1'b1);
      tick();
      checkOutput("isr_jmp", JMP_o, 1'b0);
      checkOutput("isr_stall", STALL_o, 1'b0);
      checkOutput("isr_act", INT_ACT_o, 1'b1);
      checkOutput("isr_jaddr_hold", JMP_ADDR_o, 24'h001020);
      checkReg("epc0", 3'd1, 8'h00);
      checkReg("epc1", 3'd2, 8'h04);
      checkReg("epc2", 3'd3, 8'h00);
      checkReg("code", 3'd4, 8'h05);
      checkReg("entry1", 3'd5, 8'h01);
      checkReg("isr_ctrl", 3'd0, 8'h84);

      // A fresh request pulse inside the ISR must not re-enter.
      applyStimulus(1'b0, 1'b0, 24'h001100, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 24'h001104, 1'b0);
      tick();
      checkOutput("reent_act", INT_ACT_o, 1'b1);
      checkOutput("reent_jmp", JMP_o, 1'b0);
      checkOutput("reent_stall", STALL_o, 1'b0);
      checkReg("reent_entry", 3'd5, 8'h01);

      // RETI with INT_REQ still high: return jump, one IDLE cycle, re-arm.
      applyStimulus(1'b1, 1'b0, 24'h001108, 1'b1);
      tick();
      checkOutput("ret_jmp", JMP_o, 1'b1);
      checkOutput("ret_addr", JMP_ADDR_o, 24'h000400);
      checkOutput("ret_act", INT_ACT_o, 1'b0);
      applyStimulus(1'b1, 1'b0, 24'h000400, 1'b0);
      tick();
      checkOutput("post_ret_jmp", JMP_o, 1'b0);
      checkReg("post_ret_ctrl", 3'd0, 8'h80);
      tick();
      checkReg("rearm_ctrl", 3'd0, 8'h81);

      // Request withdrawn before any boundary: spurious.
      applyStimulus(1'b0, 1'b0, 24'h000404, 1'b0);
      tick();
      checkReg("spur_ctrl", 3'd0, 8'h80);
      checkOutput("spur_stall", STALL_o, 1'b0);
      checkReg("spur1", 3'd6, 8'h01);

      // Boundary together with the request falling: still spurious.
      applyStimulus(1'b1, 1'b0, 24'h000404, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 24'h000408, 1'b0);
      tick();
      checkReg("spurb_ctrl", 3'd0, 8'h80);
      checkOutput("spurb_stall", STALL_o, 1'b0);
      checkReg("spur2", 3'd6, 8'h02);

      // GIE cleared while armed: back to IDLE without counting.
      applyStimulus(1'b1, 1'b0, 24'h00040C, 1'b0);
      tick();
      wbWrite(3'd0, 8'h00);
      checkReg("gieclr_arm", 3'd0, 8'h01);
      tick();
      checkReg("gieclr_idle", 3'd0, 8'h00);
      checkReg("gieclr_spur", 3'd6, 8'h02);

      // RETI outside the ISR is ignored.
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
      tick();
      checkOutput("stray_reti", JMP_o, 1'b0);
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
      wbWrite(3'd0, 8'h80);

      // EPC write in the RETI cycle: return uses old EPC, write still lands.
      enterIsr(24'h000800, 24'h002000, 3'd3, 1'b0);
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
      wbWrite(3'd1, 8'h56);
      checkOutput("reti_wr_jmp", JMP_o, 1'b1);
      checkOutput("reti_wr_addr", JMP_ADDR_o, 24'h000800);
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
      checkReg("reti_wr_epc0", 3'd1, 8'h56);
      tick();

      // EPC rewritten before RETI: return to the new address.
      enterIsr(24'h000900, 24'h002000, 3'd3, 1'b0);
      wbWrite(3'd1, 8'h56);
      wbWrite(3'd2, 8'h34);
      wbWrite(3'd3, 8'h12);
      exitIsr(24'h123456);

      // Asynchronous reset in FLUSH abandons the sequence.
      applyStimulus(1'b1, 1'b0, 24'h000A00, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, 24'h000A00, 1'b0);
      tick();
      checkOutput("arst_pre_stall", STALL_o, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("arst_stall", STALL_o, 1'b0);
      checkOutput("arst_jmp", JMP_o, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("arst_hold_jmp", JMP_o, 1'b0);
      end
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b0);
      checkReg("arst_ctrl", 3'd0, 8'h00);
      checkReg("arst_entry", 3'd5, 8'h00);
      checkReg("arst_spur", 3'd6, 8'h00);
      checkOutput("arst_jaddr", JMP_ADDR_o, 24'h0);
      tick();
      checkOutput("arst_after_jmp", JMP_o, 1'b0);

      // 256 entries saturate the entry counter.
      wbWrite(3'd0, 8'h80);
      for (int n = 0; n < 256; n++) begin
         enterIsr(24'h003000, 24'h004000, 3'd1, 1'b0);
         exitIsr(24'h003000);
      end
      checkReg("entry_sat", 3'd5, 8'hFF);

      // Clear write in the JUMP cycle beats the increment.
      enterIsr(24'h003100, 24'h004100, 3'd6, 1'b1);
      checkReg("entry_clr_jump", 3'd5, 8'h00);
      checkReg("code6", 3'd4, 8'h06);
      exitIsr(24'h003100);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
